// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state, LANES columns per cycle.
// Optional final-round pass-through enabled by the AES_MIXCOL_BYPASS_EN macro.
module aes_mix_columns_iter #(
  parameter int LANES = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         fwd_ninv_i,
`ifdef AES_MIXCOL_BYPASS_EN
  input  logic         bypass_i,
`endif
  input  logic [127:0] block_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] block_o
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("aes_mix_columns_iter: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [1:0] STEP = 2'(LANES);

  state_e       state_q;
  logic [127:0] work_q;
  logic [127:0] work_d;
  logic         mode_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic [1:0]   idx;
  logic [31:0]  col;
  logic [31:0]  mixed;
  logic         byp;

`ifdef AES_MIXCOL_BYPASS_EN
  assign byp = bypass_i;
`else
  assign byp = 1'b0;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are row 0 in [31:24] down to row 3 in [7:0].
  function automatic logic [31:0] mix(
    input logic [31:0] c,
    input logic        fwd
  );
    logic [3:0][7:0] a;
    logic [3:0][7:0] x2;
    logic [3:0][7:0] x4;
    logic [3:0][7:0] x8;
    logic [3:0][7:0] m9;
    logic [3:0][7:0] mb;
    logic [3:0][7:0] md;
    logic [3:0][7:0] me;
    logic [31:0]     o;
    int              i1;
    int              i2;
    int              i3;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++) begin
      i1 = (i + 1) % 4;
      i2 = (i + 2) % 4;
      i3 = (i + 3) % 4;
      if (fwd)
        o[31-8*i -: 8] = x2[i] ^ x2[i1] ^ a[i1] ^ a[i2] ^ a[i3];
      else
        o[31-8*i -: 8] = me[i] ^ mb[i1] ^ md[i2] ^ m9[i3];
    end
    return o;
  endfunction

  always_comb begin
    work_d = work_q;
    idx    = '0;
    col    = '0;
    mixed  = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = cnt_q + 2'(l);
      for (int r = 0; r < 4; r++)
        col[31-8*r -: 8] = work_q[127-8*(4*r+int'(idx)) -: 8];
      mixed = mix(col, mode_q);
      for (int r = 0; r < 4; r++)
        work_d[127-8*(4*r+int'(idx)) -: 8] = mixed[31-8*r -: 8];
    end
  end

  assign cnt_d = cnt_q + STEP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            work_q  <= block_i;
            mode_q  <= fwd_ninv_i;
            cnt_q   <= '0;
            state_q <= byp ? DONE : BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (cnt_d == 2'd0)
            state_q <= DONE;
        end
        DONE: begin
          if (ready_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign block_o = work_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench: LANES 1/2/4 instances fed in lockstep, compared to a GF(2^8) model.
// Covers known answers, latency, backpressure, input toggling and mid-block reset.
module tb_aes_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         valid;
  logic         fwd;
  logic         byp;
  logic [127:0] blk;
  logic         rdy_in;
  logic [2:0]   rdy;
  logic [2:0]   vld;
  logic [127:0] bo [3];

  int total = 0;
  int bad   = 0;
  logic [127:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AES_MIXCOL_BYPASS_EN
  `define BYP_CONN .bypass_i(byp),
`else
  `define BYP_CONN
`endif

  aes_mix_columns_iter #(.LANES(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy[0]),
    .fwd_ninv_i(fwd), `BYP_CONN .block_i(blk), .valid_o(vld[0]),
    .ready_i(rdy_in), .block_o(bo[0])
  );

  aes_mix_columns_iter #(.LANES(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy[1]),
    .fwd_ninv_i(fwd), `BYP_CONN .block_i(blk), .valid_o(vld[1]),
    .ready_i(rdy_in), .block_o(bo[1])
  );

  aes_mix_columns_iter #(.LANES(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy[2]),
    .fwd_ninv_i(fwd), `BYP_CONN .block_i(blk), .valid_o(vld[2]),
    .ready_i(rdy_in), .block_o(bo[2])
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic f);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   k [4];
    o = '0;
    if (f) k = '{8'h02, 8'h03, 8'h01, 8'h01};
    else   k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*r+c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*r+c) -: 8] = gmul(a[r], k[0]) ^ gmul(a[(r+1)%4], k[1])
                              ^ gmul(a[(r+2)%4], k[2]) ^ gmul(a[(r+3)%4], k[3]);
    end
    return o;
  endfunction

  function automatic logic [127:0] cols(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    logic [127:0] o;
    logic [31:0]  c [4];
    c = '{c0, c1, c2, c3};
    o = '0;
    for (int cc = 0; cc < 4; cc++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*r+cc) -: 8] = c[cc][31-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] b, input logic f, input logic bp,
                      input logic [127:0] exp, input int hold);
    int lat [3];
    int edges;
    int want [3];
    logic [127:0] e;
    lat = '{0, 0, 0};
    want = bp ? '{1, 1, 1} : '{5, 3, 2};
    chk("rdy_pre", 128'(rdy), 128'(3'b111));
    sb.push_back(exp);
    valid = 1'b1;
    blk   = b;
    fwd   = f;
    byp   = bp;
    @(posedge clk);
    edges = 1;
    #1;
    valid = 1'b0;
    byp   = 1'b0;
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && edges < 12) begin
      for (int d = 0; d < 3; d++)
        if (vld[d] && lat[d] == 0) lat[d] = edges;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      blk   = rnd128();
      fwd   = ~fwd;
      valid = 1'($urandom_range(1, 0));
      @(posedge clk);
      edges++;
      #1;
    end
    valid = 1'b0;
    for (int d = 0; d < 3; d++) chk($sformatf("lat%0d", d), 128'(lat[d]), 128'(want[d]));
    e = sb.pop_front();
    for (int d = 0; d < 3; d++) chk($sformatf("blk%0d", d), bo[d], e);
    chk("rdy_done", 128'(rdy), 128'(3'b000));
    for (int k = 0; k < hold; k++) begin
      blk = rnd128();
      fwd = ~fwd;
      @(posedge clk);
      #1;
      chk("hold_vld", 128'(vld), 128'(3'b111));
      chk("hold_rdy", 128'(rdy), 128'(3'b000));
      chk("hold_blk", bo[0], e);
    end
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b0;
    chk("rel_rdy", 128'(rdy), 128'(3'b111));
    chk("rel_vld", 128'(vld), 128'(3'b000));
  endtask

  logic [127:0] ka_in;
  logic [127:0] ka_out;
  logic [127:0] ki_in;
  logic [127:0] ki_out;
  logic [127:0] r;

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    fwd    = 1'b0;
    byp    = 1'b0;
    blk    = '0;
    rdy_in = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    chk("rst_rdy", 128'(rdy), 128'(3'b111));
    chk("rst_vld", 128'(vld), 128'(3'b000));
    for (int d = 0; d < 3; d++) chk($sformatf("rst_blk%0d", d), bo[d], 128'h0);
    @(posedge clk);
    #1;

    ka_in  = cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    ka_out = cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    ki_in  = cols(32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8);
    ki_out = cols(32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c);
    send(ka_in, 1'b1, 1'b0, ka_out, 0);
    send(ki_in, 1'b0, 1'b0, ki_out, 10);

    for (int n = 0; n < 4; n++) begin
      r = rnd128();
      send(r, n[0], 1'b0, model(r, n[0]), n);
    end

    valid = 1'b1;
    blk   = ka_in;
    fwd   = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_vld", 128'(vld), 128'(3'b000));
    chk("abort_rdy", 128'(rdy), 128'(3'b111));
    for (int d = 0; d < 3; d++) chk($sformatf("abort_blk%0d", d), bo[d], 128'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(ki_in, 1'b0, 1'b0, ki_out, 0);

`ifdef AES_MIXCOL_BYPASS_EN
    r = 128'h00112233445566778899aabbccddeeff;
    send(r, 1'b1, 1'b1, r, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_iter.md
AES_MIX_COLUMNS_ITER -- requirements
Module: aes_mix_columns_iter

Interface
REQ-001 SHALL have parameter LANES, default 1: number of column units instantiated; legal values 1, 2, 4.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  input block valid.
REQ-005 SHALL have port ready_o  output  1  block can be accepted.
REQ-006 SHALL have port fwd_ninv_i  input  1  1 = MixColumns, 0 = InvMixColumns; sampled with block_i.
REQ-007 SHALL have port block_i  input  128  state, big endian; byte (row r, col c) at bits [127-8*(4r+c) -: 8].
REQ-008 SHALL have port valid_o  output  1  block_o holds a finished result.
REQ-009 SHALL have port ready_i  input  1  downstream accepts block_o.
REQ-010 SHALL have port block_o  output  128  result, same byte layout as block_i.

Function
REQ-011 SHALL elaborate to an error when LANES is not 1, 2 or 4.
REQ-012 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-013 ready_o SHALL be 1 exactly in IDLE; valid_o SHALL be 1 exactly in DONE.
REQ-014 IDLE: on valid_i&&ready_o, SHALL capture block_i and fwd_ninv_i into a working register, clear column counter to 0, go BUSY.
REQ-015 BUSY: each cycle SHALL transform columns counter..counter+LANES-1 in the working register and add LANES to the 2-bit counter (mod 4).
REQ-016 BUSY SHALL go to DONE on the cycle the counter wraps to 0, i.e. after exactly 4/LANES BUSY cycles.
REQ-017 Latency: accept edge to valid_o high SHALL be 4/LANES+1 edges (5, 3, 2 for LANES 1, 2, 4).
REQ-018 Forward column math SHALL be GF(2^8) mod 0x11B, matrix rows {02 03 01 01} rotated; inverse SHALL use {0E 0B 0D 09} rotated.
REQ-019 Mode SHALL be the latched value; fwd_ninv_i, valid_i and block_i changes during BUSY/DONE SHALL be ignored.
REQ-020 DONE: block_o and valid_o SHALL hold stable while ready_i=0; on ready_i=1 SHALL go IDLE on that edge.
REQ-021 No accept in the DONE-exit cycle: ready_o SHALL be 0 there; next block is accepted no earlier than the following cycle.
REQ-022 block_o SHALL drive the working register directly (no extra output flop).

Reset
REQ-023 rst_i high SHALL immediately force IDLE, counter 0, working register 0, latched mode 1.
REQ-024 Reset outputs: ready_o=1 once rst_i deasserts, valid_o=0, block_o=128'h0.
REQ-025 Reset in BUSY or DONE SHALL abort the block; no partial result SHALL be presented.

Configuration
REQ-026 Macro AES_MIXCOL_BYPASS_EN: when defined, SHALL add port bypass_i  input  1, latched with block_i on accept.
REQ-027 With bypass latched 1, SHALL skip BUSY, go IDLE->DONE and return block_i unchanged (latency 1 edge), for the AES final round.
REQ-028 Without the macro, SHALL have no bypass_i port and always transform per REQ-015.

Verification
REQ-029 LANES=1, fwd: columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6; valid_o 5 edges after accept.
REQ-030 Each LANES, inv: columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8 -> db135345, f20a225c, d4d4d4d5, 2d26314c; latency 5/3/2.
REQ-031 Backpressure: ready_i=0 for 10 cycles in DONE -> block_o, valid_o stable; ready_o=0; then ready_i=1 -> IDLE, ready_o=1 next cycle.
REQ-032 Toggle fwd_ninv_i and block_i every cycle during BUSY -> result matches the latched mode and captured block.
REQ-033 Assert rst_i for a partial cycle mid-BUSY -> valid_o=0, block_o=0 immediately; next block processes correctly.
REQ-034 With AES_MIXCOL_BYPASS_EN, bypass_i=1, block 00112233...eeff -> same block, valid_o after 1 edge.
